data_memory_ws: RTL

//  Parametrised data memory with configurable wait states, byte enables and a ready handshake.

---
 rtl/data_memory_ws_pkg.sv | 25 ++
 rtl/data_memory_ws_mem_byte_lane_array.sv | 40 ++++
 rtl/data_memory_ws.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/data_memory_ws_pkg.sv
// Shared definitions for the wait-state data memory.
//   BIT_WIDTH      default data bus width
//   CB_READ/WRITE  ControlBus bit positions of the read and write requests
//   memState_e     access state machine encoding
//   latencyLoad    counter preload for a given access latency
package data_memory_ws_pkg;

    localparam int unsigned BIT_WIDTH = 32;

    localparam int unsigned CB_READ  = 1;
    localparam int unsigned CB_WRITE = 2;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } memState_e;

    // BUSY leaves on the edge where the counter is already zero, so a latency
    // of LAT edges needs a preload of LAT-1.
    function automatic logic [31:0] latencyLoad(input int unsigned lat);
        return 32'(lat - 1);
    endfunction

endpackage

// File: rtl/data_memory_ws_mem_byte_lane_array.sv
// Word-wide storage split into byte lanes with per-lane write enables.
//   clk        write clock
//   writeEn    commit writeData into the lanes selected by byteEn at addr
//   addr       word index shared by read and write
//   writeData  word to write
//   byteEn     per-lane write enables
//   readData   combinational read of the word at addr
module data_memory_ws_mem_byte_lane_array
    import data_memory_ws_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = BIT_WIDTH,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_WIDTH   = 10,
    parameter string       INIT_FILE   = ""
) (
    input  logic                    clk,
    input  logic                    writeEn,
    input  logic [IDX_WIDTH-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH/8-1:0] byteEn,
    output logic [DATA_WIDTH-1:0]   readData
);

    localparam int unsigned Lanes = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (writeEn) begin
            for (int unsigned lane = 0; lane < Lanes; lane++) begin
                if (byteEn[lane]) begin
                    mem[addr][8*lane +: 8] <= writeData[8*lane +: 8];
                end
            end
        end
    end

    assign readData = mem[addr];

endmodule

// File: rtl/data_memory_ws.sv
// Data memory with configurable read/write wait states, byte enables and a
// one-cycle MemReady completion pulse.
//   InputClk    clock, rising edge
//   rst         synchronous active-high reset (memory contents are kept)
//   ControlBus  [1] read request, [2] write request, [0] ignored
//   AddressBus  byte address
//   DataBusOut  write data from the CPU
//   ByteEn      write lane enables
//   DataBusIn   last read data; zero for a rejected read
//   MemReady    one-cycle completion pulse
//   MemError    access rejected (misaligned, out of range, or read+write)
//   ReadCount   completed reads
//   WriteCount  completed writes (read+write errors count here)
module data_memory_ws
    import data_memory_ws_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = BIT_WIDTH,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1,
    parameter string       INIT_FILE     = ""
) (
    input  logic                    InputClk,
    input  logic                    rst,
    input  logic [2:0]              ControlBus,
    input  logic [ADDR_WIDTH-1:0]   AddressBus,
    input  logic [DATA_WIDTH-1:0]   DataBusOut,
    input  logic [DATA_WIDTH/8-1:0] ByteEn,
    output logic [DATA_WIDTH-1:0]   DataBusIn,
    output logic                    MemReady,
    output logic                    MemError,
    output logic [31:0]             ReadCount,
    output logic [31:0]             WriteCount
);

    localparam int unsigned Lanes      = DATA_WIDTH / 8;
    localparam int unsigned OffsetBits = $clog2(Lanes);
    localparam int unsigned IdxWidth   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    memState_e             stateQ, stateD;
    logic [31:0]           cntQ, cntD;
    logic [IdxWidth-1:0]   idxQ;
    logic [DATA_WIDTH-1:0] dataQ;
    logic [Lanes-1:0]      byteEnQ;
    logic                  isWriteQ;
    logic                  errQ;

    logic                  readReq, writeReq, anyReq, accept, finish, memWriteEn;
    logic                  misaligned, outOfRange, reqErr;
    logic [ADDR_WIDTH-1:0] wordAddr;
    logic [DATA_WIDTH-1:0] readData;
    logic                  unusedReserved;

    assign readReq        = ControlBus[CB_READ];
    assign writeReq       = ControlBus[CB_WRITE];
    assign unusedReserved = ControlBus[0];
    assign anyReq         = readReq | writeReq;
    assign accept         = (stateQ == MEM_IDLE) && anyReq;

    // Range check uses the full word address so high address bits cannot alias
    // into the array.
    assign wordAddr   = AddressBus >> OffsetBits;
    assign misaligned = (AddressBus & ADDR_WIDTH'(Lanes - 1)) != '0;
    assign outOfRange = wordAddr >= ADDR_WIDTH'(DEPTH_WORDS);
    assign reqErr     = (readReq & writeReq) | misaligned | outOfRange;

    // The DONE-entry edge; rst on the same edge suppresses the commit.
    assign finish     = (stateQ == MEM_BUSY) && (cntQ == '0);
    assign memWriteEn = finish && isWriteQ && !errQ && !rst;

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        unique case (stateQ)
            MEM_IDLE: begin
                if (anyReq) begin
                    stateD = MEM_BUSY;
                    // Read+write is treated as a write-timed error access.
                    cntD   = writeReq ? latencyLoad(WRITE_LATENCY) : latencyLoad(READ_LATENCY);
                end
            end
            MEM_BUSY: begin
                if (cntQ == '0) begin
                    stateD = MEM_DONE;
                end else begin
                    cntD = cntQ - 32'd1;
                end
            end
            MEM_DONE: stateD = MEM_IDLE;
            default:  stateD = MEM_IDLE;
        endcase
    end

    always_ff @(posedge InputClk) begin
        if (rst) begin
            stateQ     <= MEM_IDLE;
            cntQ       <= '0;
            DataBusIn  <= '0;
            MemReady   <= 1'b0;
            MemError   <= 1'b0;
            ReadCount  <= '0;
            WriteCount <= '0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            MemReady <= finish;
            MemError <= finish && errQ;
            if (finish) begin
                if (isWriteQ) begin
                    WriteCount <= WriteCount + 32'd1;
                end else begin
                    ReadCount <= ReadCount + 32'd1;
                    DataBusIn <= errQ ? '0 : readData;
                end
            end
        end
    end

    // Request latch; only meaningful while BUSY, so it needs no reset.
    always_ff @(posedge InputClk) begin
        if (accept) begin
            idxQ     <= wordAddr[IdxWidth-1:0];
            dataQ    <= DataBusOut;
            byteEnQ  <= ByteEn;
            isWriteQ <= writeReq;
            errQ     <= reqErr;
        end
    end

    data_memory_ws_mem_byte_lane_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_WIDTH   (IdxWidth),
        .INIT_FILE   (INIT_FILE)
    ) uLanes (
        .clk       (InputClk),
        .writeEn   (memWriteEn),
        .addr      (idxQ),
        .writeData (dataQ),
        .byteEn    (byteEnQ),
        .readData  (readData)
    );

endmodule
